// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM state encoding,
// BCD digit limits and a digit validity helper.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // A nibble above 9 is not a legal BCD digit.
    function automatic logic bcd_invalid(input logic [3:0] digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the digit-serial BCD adder.
// master = producer/consumer side, slave = the controller.
interface bcd_serial_add_ctrl_if #(
    parameter int N = 3
);
    logic           in_valid;
    logic           in_ready;
    logic           cin;
    logic [4*N-1:0] A;
    logic [4*N-1:0] B;
    logic           out_valid;
    logic           out_ready;
    logic [4*N-1:0] Sum;
    logic           Cout;
    logic           err;
    logic           busy;

    modport master (
        output in_valid, cin, A, B, out_ready,
        input  in_ready, out_valid, Sum, Cout, err, busy
    );

    modport slave (
        input  in_valid, cin, A, B, out_ready,
        output in_ready, out_valid, Sum, Cout, err, busy
    );
endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// Illegal input digits are not trapped here; the same arithmetic is applied.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic       cin,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] t;

    // Binary add, then add 6 when the raw sum leaves the decimal range.
    always_comb begin
        t    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        d    = t[3:0];
        cout = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            d    = t[3:0] + BCD_CORR;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: one shared digit adder is stepped
// across N digits, least significant first, one digit per clock.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding digit cnt, one digit per cycle
//   DONE  | result held, out_valid high until out_ready
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_serial_add_ctrl_if.slave  bus
);

    localparam int              CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [4*N-1:0]   a_sh;
    logic [4*N-1:0]   b_sh;
    logic [4*N-1:0]   sum_r;
    logic             c_r;
    logic             cout_r;
    logic             err_r;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
    logic [3:0]       dig_d;
    logic             dig_cout;
    logic             accept;
    logic             last_dig;

    assign accept   = bus.in_valid && in_ready_c;
    assign last_dig = (cnt == LAST);

    // The current digit always sits in the low nibble of the shift registers.
    bcd_digit_add u_digit_add (
        .cin  (c_r),
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .d    (dig_d),
        .cout (dig_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_dig) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, digit stepping and result assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            c_r    <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            sum_r  <= '0;
            c_r    <= bus.cin;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                if (cnt == CNT_W'(i)) begin
                    sum_r[4*i +: 4] <= dig_d;
                end
            end
            c_r   <= dig_cout;
            err_r <= err_r | bcd_invalid(a_sh[3:0]) | bcd_invalid(b_sh[3:0]);
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            if (last_dig) begin
                cout_r <= dig_cout;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.Sum       = sum_r;
    assign bus.Cout      = cout_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed and random checks of the digit-serial BCD adder with a
// result scoreboard fed from a decimal reference model.
module tb_bcd_serial_add_ctrl;

    localparam int N = 3;

    typedef struct packed {
        logic [11:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.N(N)) bus ();

    bcd_serial_add_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] v);
        int s = 0;
        int p = 1;
        for (int i = 0; i < N; i++) begin
            s += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return s;
    endfunction

    function automatic logic [11:0] int2bcd(input int v);
        logic [11:0] r = '0;
        int s = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s /= 10;
        end
        return r;
    endfunction

    // Legal operands use plain decimal arithmetic; illegal digits follow
    // the digit-wise add-and-correct rule.
    function automatic exp_t ref_model(input logic [11:0] a, input logic [11:0] b, input logic c);
        exp_t r;
        logic bad = 1'b0;
        int   s;
        int   t;
        int   cy;
        for (int i = 0; i < N; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        if (!bad) begin
            s      = bcd2int(a) + bcd2int(b) + int'(c);
            r.sum  = int2bcd(s % 1000);
            r.cout = (s >= 1000);
            r.err  = 1'b0;
        end else begin
            cy    = int'(c);
            r.sum = '0;
            for (int i = 0; i < N; i++) begin
                t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + cy;
                if (t > 9) begin
                    r.sum[4*i +: 4] = 4'((t + 6) % 16);
                    cy = 1;
                end else begin
                    r.sum[4*i +: 4] = 4'(t);
                    cy = 0;
                end
            end
            r.cout = cy[0];
            r.err  = 1'b1;
        end
        return r;
    endfunction

    // Present operands, wait for acceptance, push expected result,
    // then scramble the inputs to show the operands were captured.
    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic c);
        int k = 0;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("in_ready_wait", 32'(k < 50), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back(ref_model(a, b, c));
        bus.A   = 12'($urandom);
        bus.B   = 12'($urandom);
        bus.cin = 1'($urandom_range(0, 1));
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
    endtask

    // Wait for a result, compare with the scoreboard, optionally stall
    // the consumer, then accept it.
    task automatic recv(input int stall, input logic chk_lat);
        int   n = 0;
        exp_t e;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_wait", 32'(n < 50), 32'd1);
        if (chk_lat) check("latency", 32'(n), 32'd4);
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sum", 32'(bus.Sum), 32'(e.sum));
            check("cout", 32'(bus.Cout), 32'(e.cout));
            check("err", 32'(bus.err), 32'(e.err));
            for (int s = 0; s < stall; s++) begin
                bus.in_valid = 1'b1;
                bus.A        = 12'h123;
                bus.B        = 12'h456;
                @(negedge clk);
                check("stall_sum", 32'(bus.Sum), 32'(e.sum));
                check("stall_cout", 32'(bus.Cout), 32'(e.cout));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ra;
        logic [11:0] rb;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        #2 rst = 1'b0;
        #10;
        check("rst_sum", 32'(bus.Sum), 32'd0);
        check("rst_cout", 32'(bus.Cout), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        send(12'h999, 12'h001, 1'b0); recv(0, 1'b1);
        send(12'h456, 12'h789, 1'b0); recv(0, 1'b1);
        send(12'h000, 12'h000, 1'b1); recv(0, 1'b0);
        send(12'h00A, 12'h000, 1'b0); recv(0, 1'b0);
        send(12'h123, 12'h456, 1'b0); recv(0, 1'b0);
        send(12'h321, 12'h679, 1'b0); recv(5, 1'b0);
        send(12'h999, 12'h999, 1'b1); recv(0, 1'b0);

        // Abort an operation in its second digit cycle.
        send(12'h567, 12'h285, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        void'(sb.pop_back());
        check("abort_sum", 32'(bus.Sum), 32'd0);
        check("abort_cout", 32'(bus.Cout), 32'd0);
        check("abort_err", 32'(bus.err), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        send(12'h567, 12'h285, 1'b0); recv(0, 1'b1);

        // Back-to-back random legal operands.
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < N; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            send(ra, rb, 1'($urandom_range(0, 1)));
            recv(0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
